// File: rtl/spi_pkg.sv
// Shared types, conf bit positions and half-period mapping for the SPI shift engine.
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned CONF_CPHA   = 32'd0;
  localparam int unsigned CONF_CPOL   = 32'd1;
  localparam int unsigned CONF_LSB    = 32'd3;
  localparam int unsigned CONF_SPD_LO = 32'd4;
  localparam int unsigned CONF_SPD_HI = 32'd6;

  // Speed select 0 is the slow card-init rate; 1..7 are power-of-two half periods.
  function automatic int unsigned half_period(input logic [2:0] spd,
                                              input int unsigned clkfreq,
                                              input int unsigned slow_hz);
    int unsigned h;
    case (spd)
      3'd0: begin
        h = clkfreq / (32'd2 * slow_hz);
        if (h == 32'd0) begin
          h = 32'd1;
        end else begin
          h = h;
        end
      end
      default: h = 32'd1 << (spd - 3'd1);
    endcase
    return h;
  endfunction

  function automatic int unsigned max_half_period(input int unsigned clkfreq,
                                                  input int unsigned slow_hz);
    int unsigned h0;
    h0 = half_period(3'd0, clkfreq, slow_hz);
    return (h0 > 32'd64) ? h0 : 32'd64;
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Loadable half-period counter: one-cycle tick every (tc+1) clocks while enabled.
module spi_clkdiv #(
  parameter int unsigned CNT_W = 32'd6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (load_i) begin
      cnt_d = '0;
      tc_d  = tc_i;
    end else if (en_i) begin
      if (cnt_q == tc_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tick_o = en_i && !load_i && (cnt_q == tc_q);

endmodule

// File: rtl/spi_xcvr.sv
// spi_xcvr: byte-wide SPI shift engine with clock division and CPOL/CPHA modes.
// Define SPI_XCVR_LSBFIRST_EN to honour conf[3] (LSB-first ordering).
module spi_xcvr
  import spi_pkg::*;
#(
  parameter int unsigned CLKFREQ = 32'd10000000,
  parameter int unsigned SLOW_HZ = 32'd400000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] conf,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       done,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk
);

  localparam int unsigned HMAX  = max_half_period(CLKFREQ, SLOW_HZ);
  localparam int unsigned CNT_W = (HMAX > 32'd1) ? $clog2(HMAX) : 32'd1;

  state_t           state_q, state_d;
  logic [3:0]       edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       rx_q, rx_d;
  logic             done_q, done_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
`ifdef SPI_XCVR_LSBFIRST_EN
  logic             lsb_q, lsb_d;
`endif

  logic             div_load_s, div_en_s, div_tick_s;
  logic [CNT_W-1:0] tc_s;
  logic             sample_s;
  logic             acc_first_s, run_next_s;
  logic [7:0]       acc_rest_s, run_rest_s, rx_shift_s;
  logic             conf_unused_s;

`ifdef SPI_XCVR_LSBFIRST_EN
  assign conf_unused_s = ^{conf[7], conf[2]};
`else
  assign conf_unused_s = ^{conf[7], conf[CONF_LSB], conf[2]};
`endif

  assign tc_s = CNT_W'(half_period(conf[CONF_SPD_HI:CONF_SPD_LO], CLKFREQ, SLOW_HZ) - 32'd1);

  spi_clkdiv #(.CNT_W(CNT_W)) u_clkdiv (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (div_load_s),
    .en_i   (div_en_s),
    .tc_i   (tc_s),
    .tick_o (div_tick_s)
  );

  // Bit-order steering: acc_* from the incoming byte, run_* from the shadow shift regs.
  always_comb begin
`ifdef SPI_XCVR_LSBFIRST_EN
    if (conf[CONF_LSB]) begin
      acc_first_s = tx[0];
      acc_rest_s  = {1'b0, tx[7:1]};
    end else begin
      acc_first_s = tx[7];
      acc_rest_s  = {tx[6:0], 1'b0};
    end
    if (lsb_q) begin
      run_next_s = tx_sr_q[0];
      run_rest_s = {1'b0, tx_sr_q[7:1]};
      rx_shift_s = {miso, rx_sr_q[7:1]};
    end else begin
      run_next_s = tx_sr_q[7];
      run_rest_s = {tx_sr_q[6:0], 1'b0};
      rx_shift_s = {rx_sr_q[6:0], miso};
    end
`else
    acc_first_s = tx[7];
    acc_rest_s  = {tx[6:0], 1'b0};
    run_next_s  = tx_sr_q[7];
    run_rest_s  = {tx_sr_q[6:0], 1'b0};
    rx_shift_s  = {rx_sr_q[6:0], miso};
`endif
  end

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_d       = rx_q;
    done_d     = 1'b0;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
`ifdef SPI_XCVR_LSBFIRST_EN
    lsb_d      = lsb_q;
`endif
    div_load_s = 1'b0;
    div_en_s   = 1'b0;
    // Leading edges (even edge_q) sample when cpha=0, trailing edges when cpha=1.
    sample_s   = ~edge_q[0] ^ cpha_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = conf[CONF_CPOL];
        mosi_d = 1'b1;
        edge_d = 4'd0;
        if (start) begin
          state_d    = S_SHIFT;
          div_load_s = 1'b1;
          cpol_d     = conf[CONF_CPOL];
          cpha_d     = conf[CONF_CPHA];
`ifdef SPI_XCVR_LSBFIRST_EN
          lsb_d      = conf[CONF_LSB];
`endif
          rx_sr_d    = 8'h00;
          if (conf[CONF_CPHA]) begin
            tx_sr_d = tx;
            mosi_d  = 1'b1;
          end else begin
            tx_sr_d = acc_rest_s;
            mosi_d  = acc_first_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        div_en_s = 1'b1;
        if (div_tick_s) begin
          if (edge_q == 4'd15) begin
            state_d = S_DONE;
            edge_d  = 4'd0;
            sclk_d  = cpol_q;
          end else begin
            edge_d  = edge_q + 4'd1;
            sclk_d  = ~sclk_q;
          end
          if (sample_s) begin
            rx_sr_d = rx_shift_s;
          end else if (edge_q != 4'd15) begin
            mosi_d  = run_next_s;
            tx_sr_d = run_rest_s;
          end else begin
            mosi_d  = mosi_q;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        div_en_s = ~done_q;
        if (done_q) begin
          state_d = S_IDLE;
          mosi_d  = 1'b1;
        end else if (div_tick_s) begin
          done_d = 1'b1;
          rx_d   = rx_sr_q;
          mosi_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        mosi_d  = 1'b1;
        edge_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      edge_q  <= 4'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      tx_sr_q <= 8'h00;
      rx_sr_q <= 8'h00;
      rx_q    <= 8'h00;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
`ifdef SPI_XCVR_LSBFIRST_EN
      lsb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
`ifdef SPI_XCVR_LSBFIRST_EN
      lsb_q   <= lsb_d;
`endif
    end
  end

  assign rx   = rx_q;
  assign done = done_q;
  assign mosi = mosi_q;
  assign sclk = sclk_q;

endmodule

// File: tb/tb_spi_xcvr.sv
// Scoreboard bench for spi_xcvr: stimulus pushes expected rx/done-cycle/edge-count, a negedge monitor checks.
module tb_spi_xcvr;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] conf;
  logic       start;
  logic [7:0] tx;
  logic [7:0] rx;
  logic       done;
  logic       miso;
  logic       mosi;
  logic       sclk;
  logic       loop_en;
  logic       miso_fix;

  always #5 clk_i = ~clk_i;

  assign miso = loop_en ? mosi : miso_fix;

  spi_xcvr #(.CLKFREQ(10000000), .SLOW_HZ(400000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .conf  (conf),
    .start (start),
    .tx    (tx),
    .rx    (rx),
    .done  (done),
    .miso  (miso),
    .mosi  (mosi),
    .sclk  (sclk)
  );

  typedef struct {
    logic [7:0] rx;
    int         cyc;
    int         edges;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   sclk_tog = 0;
  logic sclk_prev = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count sclk toggles and score every done pulse against the queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (sclk !== sclk_prev) sclk_tog++;
    sclk_prev = sclk;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no transfer pending (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_rx", rx, e.rx);
        chk("done_cycle", cyc, e.cyc);
        chk("sclk_edges", sclk_tog, e.edges);
      end
    end
  end

  // Issue one transfer; returns #1 after the posedge that accepted start (relative cycle 1).
  task automatic xfer(input logic [7:0] c, input logic [7:0] t, input logic [7:0] erx, input int h);
    exp_t e;
    conf = c;
    repeat (3) @(posedge clk_i);
    #1;
    tx       = t;
    start    = 1'b1;
    e.rx     = erx;
    e.cyc    = cyc + 17 * h + 1;
    e.edges  = sclk_tog + 16;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    start = 1'b0;
    tx    = 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk_i);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending expected 0 after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode0_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int base;

    rst_i = 1'b1; start = 1'b0; conf = 8'h00; tx = 8'h00;
    loop_en = 1'b0; miso_fix = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 1);
    chk("reset_rx", rx, 8'h00);
    chk("reset_done", done, 0);
    rst_i = 1'b0;

    // Mode 0, H=1, loopback A5: check mosi bit sequence.
    loop_en = 1'b1;
    xfer(8'h10, 8'hA5, 8'hA5, 1);
    for (int k = 0; k < 8; k++) begin
      chk("mode0_mosi_bit", mosi, mode0_bits[k]);
      repeat (2) @(posedge clk_i);
      #1;
    end
    wait_idle(40);

    // Mode 3, H=4, miso held high: sclk idles high, rx unchanged mid-transfer.
    loop_en = 1'b0; miso_fix = 1'b1;
    conf = 8'h33;
    repeat (2) @(posedge clk_i);
    #1;
    chk("mode3_idle_sclk", sclk, 1);
    xfer(8'h33, 8'h3C, 8'hFF, 4);
    repeat (20) @(posedge clk_i);
    #1;
    chk("rx_stable_mid", rx, 8'hA5);
    wait_idle(100);

    // Slow rate: speedsel 0 -> H=12.
    loop_en = 1'b1;
    xfer(8'h00, 8'h5A, 8'h5A, 12);
    wait_idle(300);

    // Start and conf change mid-transfer are ignored.
    xfer(8'h20, 8'hC3, 8'hC3, 2);
    repeat (10) @(posedge clk_i);
    #1;
    start = 1'b1; tx = 8'h00; conf = 8'h22;
    @(posedge clk_i);
    #1;
    start = 1'b0;
    wait_idle(100);
    repeat (40) @(posedge clk_i);
    #1;
    conf = 8'h10;

    // Start in the done cycle ignored; accepted the cycle after.
    begin
      exp_t e2;
      xfer(8'h10, 8'h0F, 8'h0F, 1);
      repeat (17) @(posedge clk_i);
      #1;
      start = 1'b1; tx = 8'hFF;
      @(posedge clk_i);
      #1;
      tx       = 8'hF0;
      e2.rx    = 8'hF0;
      e2.cyc   = cyc + 18;
      e2.edges = sclk_tog + 16;
      sb_q.push_back(e2);
      @(posedge clk_i);
      #1;
      start = 1'b0; tx = 8'h00;
      wait_idle(60);
    end

    // Reset after edge 7 aborts the transfer with no done.
    base = sclk_tog;
    xfer(8'h20, 8'h96, 8'h96, 2);
    for (int i = 0; i < 200 && (sclk_tog - base) < 7; i++) @(posedge clk_i);
    chk("reset_edge7_reached", (sclk_tog - base) >= 7, 1);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    sb_q.delete();
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 1);
    chk("abort_rx", rx, 8'h00);
    chk("abort_done", done, 0);
    rst_i = 1'b0;
    repeat (60) @(posedge clk_i);
    #1;
    xfer(8'h10, 8'h3C, 8'h3C, 1);
    wait_idle(40);

    // Bit order: conf[3] honoured only when the option is built in.
    xfer(8'h18, 8'h01, 8'h01, 1);
`ifdef SPI_XCVR_LSBFIRST_EN
    chk("order_first_bit", mosi, 1);
`else
    chk("order_first_bit", mosi, 0);
`endif
    wait_idle(40);

    repeat (5) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
